boton_debounce: RTL and testbench

BOTON_DEBOUNCE -- requirements
Module: boton_debounce

---
 rtl/boton_debounce_pkg.sv | 16 +
 rtl/debounce_canal.sv | 96 +++++++++
 rtl/boton_debounce.sv | 27 ++
 tb/tb_boton_debounce.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/boton_debounce_pkg.sv
// rtl/boton_debounce_pkg.sv - shared debounce FSM encoding and counter sizing
package boton_debounce_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CHK_ON  = 2'd1,
        ON      = 2'd2,
        CHK_OFF = 2'd3
    } estado_e;

    // Counter width is clog2 of the stability window, never below one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/debounce_canal.sv
// rtl/debounce_canal.sv - one button channel: 2-flop synchronizer, debounce FSM, stability counter
module debounce_canal
    import boton_debounce_pkg::*;
#(
    parameter int N_CICLOS = 500000
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_boton,
    output logic o_pulso,
    output logic o_nivel
);

    localparam int            CW      = cnt_width(N_CICLOS);
    localparam logic [CW-1:0] CNT_MAX = CW'(N_CICLOS - 1);

    logic          meta_q;
    logic          sync_q;
    estado_e       estado_q, estado_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pulso_q, pulso_d;
    logic          nivel_q, nivel_d;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= i_boton;
            sync_q <= meta_q;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            estado_q <= IDLE;
            cnt_q    <= '0;
            pulso_q  <= 1'b0;
            nivel_q  <= 1'b0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
            pulso_q  <= pulso_d;
            nivel_q  <= nivel_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        pulso_d  = 1'b0;
        case (estado_q)
            IDLE: begin
                if (sync_q) begin
                    estado_d = CHK_ON;
                    cnt_d    = '0;
                end
            end
            CHK_ON: begin
                if (!sync_q) begin
                    estado_d = IDLE;
                end else if (cnt_q == CNT_MAX) begin
                    estado_d = ON;
                    pulso_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ON: begin
                if (!sync_q) begin
                    estado_d = CHK_OFF;
                    cnt_d    = '0;
                end
            end
            CHK_OFF: begin
                // A return to 1 is bounce on release: resume ON silently.
                if (sync_q) begin
                    estado_d = ON;
                end else if (cnt_q == CNT_MAX) begin
                    estado_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                estado_d = IDLE;
                cnt_d    = '0;
            end
        endcase
        nivel_d = (estado_d == ON) || (estado_d == CHK_OFF);
    end

    assign o_pulso = pulso_q;
    assign o_nivel = nivel_q;

endmodule

// File: rtl/boton_debounce.sv
// rtl/boton_debounce.sv - N independent debounced push-button channels with press pulses
module boton_debounce
    import boton_debounce_pkg::*;
#(
    parameter int N_BOTONES = 3,
    parameter int N_CICLOS  = 500000
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic [N_BOTONES-1:0] i_boton,
    output logic [N_BOTONES-1:0] o_pulso,
    output logic [N_BOTONES-1:0] o_nivel
);

    for (genvar gi = 0; gi < N_BOTONES; gi++) begin : g_canal
        debounce_canal #(
            .N_CICLOS(N_CICLOS)
        ) u_canal (
            .i_clock(i_clock),
            .i_reset(i_reset),
            .i_boton(i_boton[gi]),
            .o_pulso(o_pulso[gi]),
            .o_nivel(o_nivel[gi])
        );
    end

endmodule

// File: tb/tb_boton_debounce.sv
// tb/tb_boton_debounce.sv - scoreboard bench for boton_debounce with a run-length reference model
module tb_boton_debounce;

    localparam int NB = 3;
    localparam int NC = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [NB-1:0] boton;
    logic [NB-1:0] pulso;
    logic [NB-1:0] nivel;

    always #10 clk = ~clk;

    boton_debounce #(
        .N_BOTONES(NB),
        .N_CICLOS (NC)
    ) dut (
        .i_clock(clk),
        .i_reset(rst),
        .i_boton(boton),
        .o_pulso(pulso),
        .o_nivel(nivel)
    );

    int checks = 0;
    int errors = 0;

    logic [2*NB-1:0] exp_q[$];

    // Model: input reaches the decision logic two edges after sampling; a level
    // flips after NC+1 consecutive decision samples that disagree with it.
    logic [NB-1:0] dly1_m, dly2_m, lvl_m, pul_m;
    int            run_m[NB];

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                dly1_m = '0;
                dly2_m = '0;
                lvl_m  = '0;
                for (int c = 0; c < NB; c++) run_m[c] = 0;
            end else begin
                pul_m = '0;
                for (int c = 0; c < NB; c++) begin
                    if (dly2_m[c] != lvl_m[c]) begin
                        run_m[c] = run_m[c] + 1;
                        if (run_m[c] == NC + 1) begin
                            lvl_m[c] = ~lvl_m[c];
                            run_m[c] = 0;
                            pul_m[c] = lvl_m[c];
                        end
                    end else begin
                        run_m[c] = 0;
                    end
                end
                dly2_m = dly1_m;
                dly1_m = boton;
                exp_q.push_back({pul_m, lvl_m});
            end
        end
    end

    logic [2*NB-1:0] exp_v;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_underflow t=%0t no expected entry", $time);
                end else begin
                    exp_v = exp_q.pop_front();
                    if ({pulso, nivel} !== exp_v) begin
                        errors++;
                        $display("FAIL scoreboard t=%0t got pulso=%b nivel=%b expected pulso=%b nivel=%b",
                                 $time, pulso, nivel, exp_v[2*NB-1:NB], exp_v[NB-1:0]);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", name, got, want);
        end
    endtask

    task automatic apply(input logic [NB-1:0] v, input int n);
        @(negedge clk);
        boton = v;
        repeat (n - 1) @(negedge clk);
    endtask

    // Edges from the first sampling edge until o_pulso goes nonzero (bounded).
    task automatic measure(output int lat, output logic [NB-1:0] val);
        lat = -1;
        val = '0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (lat < 0 && pulso != '0) begin
                lat = k;
                val = pulso;
            end
        end
    endtask

    int            lat;
    logic [NB-1:0] val;

    initial begin
        rst   = 1'b1;
        boton = '0;
        #15;
        check("reset_pulso", int'(pulso), 0);
        check("reset_nivel", int'(nivel), 0);
        @(negedge clk);
        #5 rst = 1'b0;
        apply('0, 4);

        // Clean press on channel 0
        @(negedge clk);
        boton = 3'b001;
        measure(lat, val);
        check("clean_latency", lat, 7);
        check("clean_value", int'(val), 1);
        apply(3'b001, 10);
        check("clean_nivel_held", int'(nivel[0]), 1);
        apply('0, 12);
        check("clean_nivel_released", int'(nivel[0]), 0);

        // Press bounce then stable
        apply(3'b001, 1);
        apply(3'b000, 1);
        apply(3'b001, 1);
        apply(3'b000, 1);
        @(negedge clk);
        boton = 3'b001;
        measure(lat, val);
        check("bounce_latency", lat, 7);
        check("bounce_value", int'(val), 1);

        // Release bounce from ON
        apply(3'b000, 2);
        apply(3'b001, 10);
        check("release_bounce_nivel", int'(nivel[0]), 1);
        apply(3'b000, 10);
        check("release_nivel", int'(nivel[0]), 0);

        // Simultaneous press on all channels
        @(negedge clk);
        boton = 3'b111;
        measure(lat, val);
        check("simul_latency", lat, 7);
        check("simul_value", int'(val), 7);
        apply('0, 12);

        // Async reset while channel 1 is mid-count, channel 2 already ON
        apply(3'b100, 12);
        @(negedge clk);
        boton = 3'b110;
        repeat (4) @(posedge clk);
        @(negedge clk);
        #5 rst = 1'b1;
        #1;
        check("async_reset_pulso", int'(pulso), 0);
        check("async_reset_nivel", int'(nivel), 0);
        repeat (2) @(negedge clk);
        #5 rst = 1'b0;
        measure(lat, val);
        check("post_reset_latency", lat, 7);
        check("post_reset_value", int'(val), 6);
        apply('0, 12);

        // Randomized runs of varying length around the stability window
        for (int i = 0; i < 1500; i++) begin
            apply(NB'($urandom), int'($urandom_range(1, 8)));
        end
        apply('0, 12);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
